// File: rtl/uart_rx_if.sv
// Byte-side interface of uart_rx: received byte, sticky status flags and the
// consumer's clear strobe. par_err exists only when UART_RX_PARITY_EN is defined.
interface uart_rx_if;
  // Handshake: rx_rdy is a sticky valid for rx_data. The consumer takes the byte
  // whenever it likes and answers with a one-cycle clr_rdy pulse, which also
  // clears every error flag. There is no backpressure on the serial line, so a
  // byte that completes while rx_rdy is still high raises ovr_err.
  logic [7:0] rx_data;
  logic       rx_rdy;
  logic       frm_err;
  logic       ovr_err;
  logic       clr_rdy;
`ifdef UART_RX_PARITY_EN
  logic       par_err;
`endif

  modport master (
    input  clr_rdy,
    output rx_data,
    output rx_rdy,
    output frm_err,
    output ovr_err
`ifdef UART_RX_PARITY_EN
    , output par_err
`endif
  );

  modport slave (
    output clr_rdy,
    input  rx_data,
    input  rx_rdy,
    input  frm_err,
    input  ovr_err
`ifdef UART_RX_PARITY_EN
    , input  par_err
`endif
  );
endinterface

// File: rtl/uart_rx.sv
// UART receiver, 8N1 (8E1 with even parity when UART_RX_PARITY_EN is defined).
// Samples each bit at its midpoint from a start-edge-aligned baud counter.
module uart_rx #(
  parameter int BAUD_CNT = 2604
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  uart_rx_if.master  bus,
  output logic [2:0] state_dbg
);

  localparam int HALF_CNT = BAUD_CNT / 2;
  localparam logic [11:0] BAUD_M1 = 12'(BAUD_CNT - 1);
  localparam logic [11:0] HALF_M1 = 12'(HALF_CNT - 1);

  if (BAUD_CNT < 8 || BAUD_CNT > 4096 || (BAUD_CNT % 2) != 0) begin : g_bad_baud
    $error("uart_rx: BAUD_CNT must be even and within 8..4096");
  end

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    STOP   = 3'd3,
    PARITY = 3'd4
  } state_t;

  state_t      state, state_nxt;
  logic        rx_meta, rx_s, rx_s_d;
  logic        fall;
  logic [11:0] cnt, cnt_nxt;
  logic        strobe;
  logic [2:0]  bit_idx;
  logic [7:0]  shift;
  logic        cmp_vld;
  logic        cmp_stop;
`ifdef UART_RX_PARITY_EN
  logic        par_bit;
  logic        cmp_perr;
`endif

  assign state_dbg = state;

  // Flops preset high so a line that idles high never looks like a start edge out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      rx_s_d  <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
      rx_s_d  <= rx_s;
    end
  end

  assign fall = rx_s_d & ~rx_s;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= 12'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    strobe    = 1'b0;
    case (state)
      IDLE: begin
        if (fall) state_nxt = START;
      end
      START: begin
        if (cnt == HALF_M1) begin
          strobe    = 1'b1;
          state_nxt = rx_s ? IDLE : DATA;
        end
      end
      DATA: begin
        if (cnt == BAUD_M1) begin
          strobe = 1'b1;
          if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_nxt = PARITY;
`else
            state_nxt = STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (cnt == BAUD_M1) begin
          strobe    = 1'b1;
          state_nxt = STOP;
        end
      end
`endif
      STOP: begin
        // Leaving at mid stop bit leaves half a bit to catch a back-to-back start edge.
        if (cnt == BAUD_M1) begin
          strobe    = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase

    if (state == IDLE || strobe || state_nxt != state) begin
      cnt_nxt = 12'd0;
    end else begin
      cnt_nxt = cnt + 12'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_idx  <= 3'd0;
      shift    <= 8'h00;
      cmp_vld  <= 1'b0;
      cmp_stop <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bit  <= 1'b0;
      cmp_perr <= 1'b0;
`endif
    end else begin
      cmp_vld <= 1'b0;
      if (state == START && strobe) begin
        bit_idx <= 3'd0;
      end
      if (state == DATA && strobe) begin
        shift   <= {rx_s, shift[7:1]};
        bit_idx <= bit_idx + 3'd1;
      end
`ifdef UART_RX_PARITY_EN
      if (state == PARITY && strobe) begin
        par_bit <= rx_s;
      end
`endif
      if (state == STOP && strobe) begin
        cmp_vld  <= 1'b1;
        cmp_stop <= rx_s;
`ifdef UART_RX_PARITY_EN
        cmp_perr <= ^{shift, par_bit};
`endif
      end
    end
  end

  // A completing frame overrides a coincident clr_rdy; the clear only removes stale state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.rx_data <= 8'h00;
      bus.rx_rdy  <= 1'b0;
      bus.frm_err <= 1'b0;
      bus.ovr_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      bus.par_err <= 1'b0;
`endif
    end else if (cmp_vld) begin
      bus.rx_data <= shift;
      if (bus.clr_rdy) begin
        bus.rx_rdy  <= cmp_stop;
        bus.frm_err <= ~cmp_stop;
        bus.ovr_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
        bus.par_err <= cmp_perr;
`endif
      end else begin
        if (cmp_stop) begin
          bus.rx_rdy <= 1'b1;
          if (bus.rx_rdy) bus.ovr_err <= 1'b1;
        end else begin
          bus.frm_err <= 1'b1;
        end
`ifdef UART_RX_PARITY_EN
        if (cmp_perr) bus.par_err <= 1'b1;
`endif
      end
    end else if (bus.clr_rdy) begin
      bus.rx_rdy  <= 1'b0;
      bus.frm_err <= 1'b0;
      bus.ovr_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      bus.par_err <= 1'b0;
`endif
    end
  end

endmodule
